// File: rtl/mux_arb_reg.sv
// rtl/mux_arb_reg.sv - NCH-way source mux with direct/round-robin grant and registered output
module mux_arb_reg #(
  parameter int WIDTH     = 8,
  parameter int NCH       = 3,
  parameter int SEL_W     = 2,
  parameter int NARROW_CH = 2,
  parameter int NARROW_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]     in_valid,
  output logic [NCH-1:0]     in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  // Upper bits forced to one on the narrow channel; all-zero when NARROW_W == WIDTH.
  localparam logic [WIDTH-1:0] HI_ONES = ~({WIDTH{1'b1}} >> (WIDTH - NARROW_W));

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             grant;
  logic [SEL_W-1:0] gidx;
  logic             load;
  logic             xfer_in;
  logic [WIDTH-1:0] gdata;
  int               idx;

  assign load    = !out_valid_q || out_ready;
  assign xfer_in = grant && load;

  // Direct select, or a priority search rotated to start just after rr_ptr.
  always_comb begin
    grant = 1'b0;
    gidx  = '0;
    idx   = 0;
    if (!mode) begin
      for (int k = 0; k < NCH; k++) begin
        if (sel == SEL_W'(k) && in_valid[k]) begin
          grant = 1'b1;
          gidx  = SEL_W'(k);
        end
      end
    end else begin
      for (int off = 1; off <= NCH; off++) begin
        idx = (int'(rr_ptr_q) + off) % NCH;
        if (!grant && in_valid[idx]) begin
          grant = 1'b1;
          gidx  = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    gdata    = '0;
    in_ready = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gidx == SEL_W'(k)) begin
        gdata       = in_data[k*WIDTH +: WIDTH];
        in_ready[k] = xfer_in;
      end
    end
    if (int'(gidx) == NARROW_CH) begin
      gdata = gdata | HI_ONES;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer_in) begin
      out_data_d  = gdata;
      out_chan_d  = gidx;
      out_valid_d = 1'b1;
      if (mode) begin
        rr_ptr_d = gidx;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= SEL_W'(NCH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_reg.sv
// tb/tb_mux_arb_reg.sv - directed bench for mux_arb_reg (default and wide parameter sets)
module tb_mux_arb_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [23:0] in_data;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  logic        d2_mode;
  logic [2:0]  d2_sel;
  logic [79:0] d2_in_data;
  logic [4:0]  d2_in_valid;
  logic [4:0]  d2_in_ready;
  logic [15:0] d2_out_data;
  logic [2:0]  d2_out_chan;
  logic        d2_out_valid;
  logic        d2_out_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_arb_reg dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mux_arb_reg #(.WIDTH(16), .NCH(5), .SEL_W(3), .NARROW_CH(4), .NARROW_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .mode(d2_mode), .sel(d2_sel),
    .in_data(d2_in_data), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .out_data(d2_out_data), .out_chan(d2_out_chan), .out_valid(d2_out_valid),
    .out_ready(d2_out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b0;
    d2_mode = 1'b0; d2_sel = '0; d2_in_data = '0; d2_in_valid = '0; d2_out_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data",  32'(out_data),  32'h00);
    chk("rst_chan",  32'(out_chan),  32'h0);
    chk("rst_ready", 32'(in_ready),  32'h0);

    // direct select
    in_data = {8'h05, 8'h22, 8'h11};
    mode = 1'b0; sel = 2'd1; in_valid = 3'b111; out_ready = 1'b1;
    #1 chk("dir_ready1", 32'(in_ready), 32'b010);
    step();
    chk("dir_valid1", 32'(out_valid), 32'h1);
    chk("dir_data1",  32'(out_data),  32'h22);
    chk("dir_chan1",  32'(out_chan),  32'h1);
    sel = 2'd2;
    #1 chk("dir_ready2", 32'(in_ready), 32'b100);
    step();
    chk("dir_data2", 32'(out_data), 32'hFD);
    chk("dir_chan2", 32'(out_chan), 32'h2);
    sel = 2'd3;
    #1 chk("dir_ready3", 32'(in_ready), 32'b000);
    step();
    chk("dir_valid3", 32'(out_valid), 32'h0);

    // round robin, all valid, then channel 1 idle
    mode = 1'b1; in_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_valid", 32'(out_valid), 32'h1);
      chk("rr_chan",  32'(out_chan),  32'(i % 3));
    end
    in_valid = 3'b101;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_skip_valid", 32'(out_valid), 32'h1);
      chk("rr_skip_chan",  32'(out_chan),  (i % 2 == 0) ? 32'h0 : 32'h2);
    end

    // backpressure holding 0x22
    mode = 1'b0; sel = 2'd1; in_valid = 3'b111;
    step();
    chk("bp_load", 32'(out_data), 32'h22);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_ready", 32'(in_ready), 32'h0);
      step();
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_data",  32'(out_data),  32'h22);
      chk("bp_chan",  32'(out_chan),  32'h1);
    end
    sel = 2'd0; out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'b001);
    step();
    chk("bp_next_data", 32'(out_data), 32'h11);
    chk("bp_next_chan", 32'(out_chan), 32'h0);

    // reset while stalled
    out_ready = 1'b0;
    step();
    chk("mr_pre_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1 chk("mr_async_valid", 32'(out_valid), 32'h0);
    step();
    mode = 1'b1; in_valid = 3'b111; out_ready = 1'b1;
    rst_n = 1'b1;
    #1 chk("mr_ready", 32'(in_ready), 32'b001);
    step();
    chk("mr_valid", 32'(out_valid), 32'h1);
    chk("mr_chan",  32'(out_chan),  32'h0);
    in_valid = 3'b000;

    // wide parameter set
    d2_in_data = {16'hAB55, 16'h4444, 16'h3333, 16'h1234, 16'h0000};
    d2_in_valid = 5'b11111; d2_out_ready = 1'b1; d2_mode = 1'b0; d2_sel = 3'd4;
    step();
    chk("p2_narrow_data", 32'(d2_out_data), 32'hFF55);
    chk("p2_narrow_chan", 32'(d2_out_chan), 32'h4);
    d2_sel = 3'd1;
    step();
    chk("p2_wide_data", 32'(d2_out_data), 32'h1234);
    chk("p2_wide_chan", 32'(d2_out_chan), 32'h1);
    for (int s = 5; s < 8; s++) begin
      d2_sel = 3'(s);
      #1 chk("p2_oor_ready", 32'(d2_in_ready), 32'h0);
      step();
      chk("p2_oor_valid", 32'(d2_out_valid), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_arb_reg.md
Name: mux_arb_reg

Overview:
Parametrised successor to the address-path source multiplexers. It selects one of NCH source channels into a registered output, using either an externally driven select or round-robin arbitration. Transfers on both sides use a valid/ready handshake. One designated narrow channel is ones-extended to full width, which covers the word-count path. It sits between the address/word-count registers and the downstream counter and output logic.

Parameters:
WIDTH, 8, data width of every channel and of the output.
NCH, 3, number of input channels (2..8).
SEL_W, 2, select/channel-index width; 2**SEL_W >= NCH is required.
NARROW_CH, 2, index of the ones-extended channel; set to NCH or greater to disable.
NARROW_W, 3, valid low bits of channel NARROW_CH (1..WIDTH).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
mode  in  1  0 = direct select, 1 = round robin.
sel  in  SEL_W  channel select, used when mode=0.
in_data  in  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
in_valid  in  NCH  per-channel valid.
in_ready  out  NCH  per-channel ready; one-hot or zero.
out_data  out  WIDTH  registered output data.
out_chan  out  SEL_W  index of the channel that supplied out_data.
out_valid  out  1  output register holds a word.
out_ready  in  1  downstream accepts.

Behaviour:
- Reset (async assert, sync release) clears out_valid, out_data and out_chan to 0 and sets rr_ptr to NCH-1, so channel 0 has first round-robin priority. in_ready is combinationally 0 while out_valid=0 and no in_valid is set.
- Load condition: load = !out_valid || out_ready.
- Grant g, mode=0:
  - g = sel when sel < NCH and in_valid[sel]=1.
  - Otherwise there is no grant, including when sel >= NCH.
  - Valid on other channels is ignored.
- Grant g, mode=1:
  - g = first k with in_valid[k]=1, searching from (rr_ptr+1) mod NCH upward with wrap.
  - No grant if no valid is set.
- in_ready[g] = load && grant. Every other in_ready bit is 0, and in_ready is combinational from the inputs and out_valid.
- Transfer in: on a cycle with in_valid[g] && in_ready[g], the next edge sets:
  - out_data = channel g data. When g == NARROW_CH, out_data = {ones(WIDTH-NARROW_W), data[NARROW_W-1:0]}, and the upper input bits are ignored.
  - out_chan = g and out_valid = 1.
  - rr_ptr = g, only when mode=1. rr_ptr holds in mode=0.
- Transfer out: out_valid && out_ready. If no new grant occurs in the same cycle, out_valid falls on the next edge.
- Simultaneous drain and load give back-to-back words every cycle with no bubble. Throughput is 1 word/cycle and latency is 1 cycle from input handshake to out_valid.
- Stall: while out_valid && !out_ready, out_data and out_chan stay stable and all in_ready are 0.
- Mode or sel changes take effect in the same cycle for the grant decision. An already-registered word is unaffected.
- Reset mid-transfer discards the held word; out_valid drops immediately on rst_n=0.
- out_data holds its last value when out_valid=0. Downstream must not sample it then.
- Width rule: NARROW_W = WIDTH means no extension is applied.
- Implementation target: about 150 lines of RTL, with the round-robin search as a rotated priority encoder.

Test Plan:
1. Reset: after rst_n low then high, with all in_valid=0 -> out_valid=0, out_data=0x00, out_chan=0, in_ready=000.
2. Direct select:
   - Setup: mode=0, sel=1, in_valid=111, ch0=0x11, ch1=0x22, ch2=0x05, out_ready=1 -> in_ready=010 and next cycle out_data=0x22, out_chan=1.
   - Then sel=2 -> out_data=0xFD (ones-extended 3'b101).
   - Then sel=3 -> in_ready=000 and out_valid falls.
3. Round robin: mode=1, in_valid=111, out_ready=1 for 6 cycles -> out_chan sequence 0,1,2,0,1,2, one word per cycle with no bubble. Then in_valid=101 -> sequence skips channel 1 (0,2,0,2).
4. Backpressure: out_ready=0 with out_valid=1 holding 0x22 for 5 cycles -> out_data stays 0x22 and in_ready=000 throughout. Raising out_ready -> 0x22 is consumed and the next granted word appears the following cycle.
5. Mid-operation reset: pull rst_n low while out_valid=1 and out_ready=0 -> out_valid=0 immediately. After release in mode=1 with in_valid=111 -> first out_chan=0.
6. Parameter sweep: WIDTH=16, NCH=5, SEL_W=3, NARROW_CH=4, NARROW_W=8, ch4 in_data=0xAB55 -> out_data=0xFF55. sel=5..7 in mode=0 -> no grant.
